ct_spsram_128x104_ctrl: RTL and testbench

CT_SPSRAM_128X104_CTRL -- requirements
Module: ct_spsram_128x104_ctrl

---
 rtl/ct_spsram_128x104_ctrl_pkg.sv | 9 +
 rtl/ct_spsram_128x104_ctrl_if.sv | 33 +++
 rtl/ct_spsram_128x104_ctrl_rsp_fifo.sv | 58 +++++
 rtl/ct_spsram_128x104_ctrl.sv | 95 +++++++++
 tb/tb_ct_spsram_128x104_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_spsram_128x104_ctrl_pkg.sv
// Shared widths and FSM encoding for the 128x104 single-port SRAM controller.
package ct_spsram_ctrl_pkg;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 104;
    localparam int DEPTH      = 128;
    localparam int RSP_DEPTH  = 2;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/ct_spsram_128x104_ctrl_if.sv
// Request, response, status and SRAM-pin bundle of the 128x104 SRAM controller.
interface ct_spsram_128x104_ctrl_if;
    import ct_spsram_ctrl_pkg::*;

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        output req_rdy, rsp_vld, rsp_rdata, init_done,
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        input  req_rdy, rsp_vld, rsp_rdata, init_done,
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );
endinterface

// File: rtl/ct_spsram_128x104_ctrl_rsp_fifo.sv
// Small in-order response buffer; a push and pop in the same cycle keep occupancy.
module ct_spsram_rsp_fifo #(
    parameter int DATA_WIDTH = 104,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  logic [DATA_WIDTH-1:0]              push_data_i,
    input  logic                               pop_i,
    output logic                               vld_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     count_o
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (!push_i && pop_ok) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    assign vld_o   = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Credit flow upstream must make this unreachable.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_ok && (cnt_q == CW'(RSP_DEPTH))));
endmodule

// File: rtl/ct_spsram_128x104_ctrl.sv
// Front end for an external 128x104 single-port SRAM: zero-fill after reset,
// then single-cycle request issue with credit-limited, in-order read responses.
module ct_spsram_128x104_ctrl
    import ct_spsram_ctrl_pkg::*;
(
    input logic                      forever_cpuclk,
    input logic                      cpurst_b,
    ct_spsram_128x104_ctrl_if.slave  bus
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a_q, a_c;
    logic [DATA_WIDTH-1:0] d_q, d_c, wen_c;
    logic                  cen_c, gwen_c;
    logic                  inflight_q;
    logic [CW-1:0]         occ;
    logic                  req_rdy, req_acc;

    // Credits count both buffered responses and the read still inside the SRAM.
    assign req_rdy = (state_q == RUN) &&
                     (({1'b0, occ} + (CW+1)'(inflight_q)) < (CW+1)'(RSP_DEPTH));
    assign req_acc = bus.req_vld && req_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cen_c   = 1'b1;
        gwen_c  = 1'b1;
        wen_c   = '1;
        a_c     = a_q;
        d_c     = d_q;
        case (state_q)
            INIT: begin
                cen_c  = 1'b0;
                gwen_c = 1'b0;
                wen_c  = '0;
                a_c    = cnt_q;
                d_c    = '0;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = RUN;
            end
            RUN: begin
                if (req_acc) begin
                    cen_c  = 1'b0;
                    gwen_c = ~bus.req_wr;
                    wen_c  = bus.req_wr ? ~bus.req_wmask : '1;
                    a_c    = bus.req_addr;
                    d_c    = bus.req_wdata;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= req_acc && !bus.req_wr;
            a_q        <= a_c;
            d_q        <= d_c;
        end
    end

    ct_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (forever_cpuclk),
        .rst_ni      (cpurst_b),
        .push_i      (inflight_q),
        .push_data_i (bus.sram_q),
        .pop_i       (bus.rsp_rdy),
        .vld_o       (bus.rsp_vld),
        .data_o      (bus.rsp_rdata),
        .count_o     (occ)
    );

    // Reset state is INIT, which would otherwise enable the SRAM while reset is held.
    assign bus.sram_cen  = cen_c  | ~cpurst_b;
    assign bus.sram_gwen = gwen_c | ~cpurst_b;
    assign bus.sram_wen  = wen_c  | {DATA_WIDTH{~cpurst_b}};
    assign bus.sram_a    = a_c;
    assign bus.sram_d    = d_c;
    assign bus.req_rdy   = req_rdy;
    assign bus.init_done = (state_q == RUN);
endmodule

// File: tb/tb_ct_spsram_128x104_ctrl.sv
// Bench for ct_spsram_128x104_ctrl: directed vector table, corner sequences and
// random traffic against a memory-array / response-queue reference model.
module tb_ct_spsram_128x104_ctrl;
    import ct_spsram_ctrl_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] PA5  = {13{8'hA5}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ct_spsram_128x104_ctrl_if bus();

    ct_spsram_128x104_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus)
    );

    // Behavioural SRAM: per-bit masked write, read data one cycle later.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_q_r;
    assign bus.sram_q = sram_q_r;
    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_gwen)
                sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
            else
                sram_q_r <= sram_mem[bus.sram_a];
        end
    end

    // Reference model: memory contents plus queue of outstanding read results.
    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          exp_q [$];
    int            n_cmp = 0, n_bad = 0;
    int            cycle_n = 0, acc_cnt = 0;
    bit            model_on = 0, last_acc, last_pop;
    logic [DW-1:0] pop_data;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic observe();
        logic exp_v;
        last_acc = 0;
        last_pop = 0;
        if (!model_on) return;
        cycle_n++;
        chk1("req_rdy", bus.req_rdy, exp_q.size() < 2);
        exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cycle_n);
        chk1("rsp_vld", bus.rsp_vld, exp_v);
        if (exp_v) chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
        if (bus.rsp_vld && bus.rsp_rdy && exp_q.size() > 0) begin
            last_pop = 1;
            pop_data = bus.rsp_rdata;
            void'(exp_q.pop_front());
        end
        if (bus.req_vld && bus.req_rdy) begin
            last_acc = 1;
            acc_cnt++;
            chk("sram_issue", DW'({bus.sram_cen, bus.sram_gwen, bus.sram_a}),
                DW'({1'b0, ~bus.req_wr, bus.req_addr}));
            if (bus.req_wr) begin
                chk("sram_wen", bus.sram_wen, ~bus.req_wmask);
                chk("sram_d", bus.sram_d, bus.req_wdata);
                ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask) |
                                        (bus.req_wdata & bus.req_wmask);
            end else begin
                exp_q.push_back('{ref_mem[bus.req_addr], cycle_n + 2});
            end
        end else begin
            chk("sram_idle", DW'({bus.sram_cen, bus.sram_gwen, &bus.sram_wen}), DW'(3'b111));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_pins"}, DW'({bus.req_rdy, bus.rsp_vld, bus.init_done, bus.sram_cen, bus.sram_gwen,
                                &bus.sram_wen, |bus.sram_d, bus.sram_a}),
            DW'({7'b0001110, 7'd0}));
        chk({nm, "_rdata"}, bus.rsp_rdata, '0);
    endtask

    // Checks n consecutive zero-fill cycles starting at address 0.
    task automatic init_seq(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("init_wr", DW'({bus.sram_cen, bus.sram_gwen, |bus.sram_wen, |bus.sram_d, bus.init_done,
                                bus.req_rdy, bus.rsp_vld, bus.sram_a}),
                DW'({7'b0, 7'(i)}));
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic [DW-1:0] exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vt [NV];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int ok, got, lat, guard, acc0;
        logic [DW-1:0] wd;

        vt[0] = '{1'b1, 7'd5,   PA5,            ONES,       '0};
        vt[1] = '{1'b0, 7'd5,   '0,             '0,         PA5};
        vt[2] = '{1'b1, 7'd9,   ONES,           DW'('hFF),  '0};
        vt[3] = '{1'b0, 7'd9,   '0,             '0,         DW'('hFF)};
        vt[4] = '{1'b1, 7'd127, DW'('h123456789), ONES,     '0};
        vt[5] = '{1'b0, 7'd127, '0,             '0,         DW'('h123456789)};
        vt[6] = '{1'b1, 7'd5,   '0,             DW'('hF0),  '0};
        vt[7] = '{1'b0, 7'd5,   '0,             '0,         {{12{8'hA5}}, 8'h05}};

        for (int i = 0; i < DEPTH; i++) sram_mem[i] = DW'({$urandom, $urandom, $urandom, $urandom});
        sram_q_r      = '0;
        bus.req_vld   = 0;
        bus.req_wr    = 0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_rdy   = 1;

        #1 check_reset("reset");
        @(posedge clk); #1 rst_n = 1;
        init_seq(DEPTH);
        @(negedge clk);
        chk1("init_done", bus.init_done, 1'b1);
        chk1("rdy_after_init", bus.req_rdy, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        model_on = 1;

        // Directed vectors, one transaction at a time.
        for (int v = 0; v < NV; v++) begin
            bus.req_wr    = vt[v].wr;
            bus.req_addr  = vt[v].addr;
            bus.req_wdata = vt[v].wdata;
            bus.req_wmask = vt[v].wmask;
            bus.req_vld   = 1;
            ok = 0;
            for (int t = 0; t < 8 && ok == 0; t++) begin cyc(); ok = int'(last_acc); end
            bus.req_vld = 0;
            chk1("vec_accept", ok[0], 1'b1);
            if (!vt[v].wr) begin
                got = 0; lat = 0;
                for (int t = 1; t <= 8 && got == 0; t++) begin
                    cyc();
                    if (last_pop) begin got = 1; lat = t; end
                end
                chk("vec_lat", DW'(lat), DW'(2));
                chk("vec_rdata", pop_data, vt[v].exp);
            end
        end

        // Read of the address written in the immediately preceding cycle.
        wd = DW'({$urandom, $urandom, $urandom, $urandom});
        bus.req_vld = 1; bus.req_wr = 1; bus.req_addr = 7'd20; bus.req_wdata = wd; bus.req_wmask = ONES;
        cyc();
        chk1("raw_wr_acc", last_acc, 1'b1);
        bus.req_wr = 0;
        cyc();
        chk1("raw_rd_acc", last_acc, 1'b1);
        bus.req_vld = 0;
        got = 0;
        for (int t = 0; t < 8 && got == 0; t++) begin cyc(); got = int'(last_pop); end
        chk("raw_rdata", pop_data, wd);

        // Back-to-back reads with the consumer stalled: only two credits.
        bus.rsp_rdy = 0; bus.req_vld = 1; bus.req_wr = 0;
        acc0 = acc_cnt;
        for (int k = 0; k < 6; k++) begin
            bus.req_addr = (k % 2 == 0) ? 7'd5 : 7'd9;
            cyc();
        end
        chk("stall_acc", DW'(acc_cnt - acc0), DW'(2));
        @(negedge clk);
        chk1("stall_rdy", bus.req_rdy, 1'b0);
        @(posedge clk); #1;
        bus.req_vld = 0; bus.rsp_rdy = 1;
        for (int k = 0; k < 4; k++) cyc();
        chk("stall_drain", DW'(exp_q.size()), DW'(0));
        @(negedge clk);
        chk1("stall_rdy_back", bus.req_rdy, 1'b1);
        @(posedge clk); #1;

        // Random traffic with random consumer back-pressure.
        guard = 0;
        while (acc_cnt < 10000 + acc0 + 20 && guard < 60000) begin
            bus.req_vld   = ($urandom_range(0, 3) != 0);
            bus.req_wr    = $urandom_range(0, 1);
            bus.req_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
            bus.req_wdata = DW'({$urandom, $urandom, $urandom, $urandom});
            bus.req_wmask = $urandom_range(0, 3) == 0 ? ONES : DW'({$urandom, $urandom, $urandom, $urandom});
            bus.rsp_rdy   = ($urandom_range(0, 9) < 7);
            cyc();
            guard++;
        end
        chk1("rand_budget", guard < 60000, 1'b1);
        bus.req_vld = 0; bus.rsp_rdy = 1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
        chk("rand_drain", DW'(exp_q.size()), DW'(0));

        // Reset while a read is inside the SRAM: the read must vanish.
        bus.req_vld = 1; bus.req_wr = 0; bus.req_addr = 7'd5; bus.rsp_rdy = 0;
        cyc();
        bus.req_vld = 0;
        #2 rst_n = 0;
        model_on = 0;
        exp_q.delete();
        #1 check_reset("rst_rd");
        bus.rsp_rdy = 1;
        @(posedge clk); #1 rst_n = 1;
        init_seq(60);

        // Reset at zero-fill address 60, then a full restart from 0.
        #3 rst_n = 0;
        #1 check_reset("rst_init");
        @(posedge clk); #1 rst_n = 1;
        init_seq(DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cycle_n = 0;
        model_on = 1;
        for (int k = 0; k < 5; k++) cyc();
        bus.req_vld = 1; bus.req_wr = 0; bus.req_addr = 7'd5;
        cyc();
        bus.req_vld = 0;
        got = 0;
        for (int t = 0; t < 8 && got == 0; t++) begin cyc(); got = int'(last_pop); end
        chk("post_reset_rdata", pop_data, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
